// File: rtl/pipeline_wb_stage_mp.sv
// Write-back stage: per-lane result select and load formatting, qualified
// register-file write port per lane, and a retired-instruction counter.
module pipeline_wb_stage_mp #(
  parameter int XLEN  = 64,
  parameter int LANES = 2,
  parameter int CNT_W = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    flush,
  input  logic [LANES-1:0]        valid_MEM,
  input  logic [2*LANES-1:0]      rf_wr_sel,
  input  logic [3*LANES-1:0]      ld_funct3,
  input  logic [XLEN*LANES-1:0]   alu_result_MEM,
  input  logic [XLEN*LANES-1:0]   mem_data_MEM,
  input  logic [XLEN*LANES-1:0]   pc_MEM,
  input  logic [5*LANES-1:0]      rd_MEM,
  input  logic [LANES-1:0]        reg_write_MEM,
  output logic [XLEN*LANES-1:0]   write_data_WB,
  output logic [5*LANES-1:0]      rd_WB,
  output logic [LANES-1:0]        reg_write_WB,
  output logic [LANES-1:0]        valid_WB,
  output logic [CNT_W-1:0]        instret
);

  logic [XLEN*LANES-1:0] sel_data;
  logic [LANES-1:0]      we_q;
  logic [CNT_W-1:0]      retire_inc;

  // Formatting is done at 64 bits and truncated, so for XLEN=32 the word
  // codes naturally collapse to passing the raw data.
  function automatic logic [XLEN-1:0] format_load(input logic [XLEN-1:0] data,
                                                  input logic [2:0] funct3);
    logic [63:0] d64;
    logic [63:0] r64;
    d64 = 64'(data);
    case (funct3)
      3'b000:  r64 = {{56{d64[7]}},  d64[7:0]};
      3'b001:  r64 = {{48{d64[15]}}, d64[15:0]};
      3'b010:  r64 = {{32{d64[31]}}, d64[31:0]};
      3'b100:  r64 = {56'd0, d64[7:0]};
      3'b101:  r64 = {48'd0, d64[15:0]};
      3'b110:  r64 = {32'd0, d64[31:0]};
      default: r64 = d64;
    endcase
    return XLEN'(r64);
  endfunction

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < LANES; i++) begin
      case (rf_wr_sel[2*i +: 2])
        2'b01:   sel_data[XLEN*i +: XLEN] = pc_MEM[XLEN*i +: XLEN] + XLEN'(4);
        2'b10:   sel_data[XLEN*i +: XLEN] = alu_result_MEM[XLEN*i +: XLEN];
        2'b11:   sel_data[XLEN*i +: XLEN] = format_load(mem_data_MEM[XLEN*i +: XLEN],
                                                        ld_funct3[3*i +: 3]);
        default: sel_data[XLEN*i +: XLEN] = '0;
      endcase
    end
  end

  // The younger lane owns a shared destination; the older write is dropped.
  always_comb begin
    we_q = '0;
    for (int i = 0; i < LANES; i++) begin
      we_q[i] = valid_MEM[i] & reg_write_MEM[i] & (rd_MEM[5*i +: 5] != 5'd0);
    end
    if (LANES == 2) begin
      if (we_q[0] && we_q[LANES-1] && (rd_MEM[4:0] == rd_MEM[5*(LANES-1) +: 5])) begin
        we_q[0] = 1'b0;
      end
    end
  end

  always_comb begin
    retire_inc = '0;
    for (int i = 0; i < LANES; i++) begin
      retire_inc = retire_inc + CNT_W'(valid_MEM[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      write_data_WB <= '0;
      rd_WB         <= '0;
      reg_write_WB  <= '0;
      valid_WB      <= '0;
      instret       <= '0;
    end else if (flush) begin
      write_data_WB <= '0;
      rd_WB         <= '0;
      reg_write_WB  <= '0;
      valid_WB      <= '0;
    end else if (!stall) begin
      write_data_WB <= sel_data;
      rd_WB         <= rd_MEM;
      reg_write_WB  <= we_q;
      valid_WB      <= valid_MEM;
      instret       <= instret + retire_inc;
    end
  end

endmodule
